// File: rtl/matrix_scan_ctrl_if.sv
// Bus bundle between the scan controller, the frame RAM and the panel drivers.
// SCAN_DOUBLE_BUFFER_EN adds bank_o and widens rd_addr_o by one bank bit.
interface matrix_scan_ctrl_if #(
  parameter int unsigned RowW  = 32,
  parameter int unsigned ColW  = 16,
  parameter int unsigned AddrW = 4
);
`ifdef SCAN_DOUBLE_BUFFER_EN
  localparam int unsigned RdAddrW = AddrW + 1;
`else
  localparam int unsigned RdAddrW = AddrW;
`endif

  logic               frame_valid_i;
  logic               frame_ready_o;
  logic               rd_en_o;
  logic [RdAddrW-1:0] rd_addr_o;
  logic [RowW-1:0]    rd_data_i;
  logic               serial_o;
  logic               shift_en_o;
  logic               latch_o;
  logic               blank_o;
  logic [ColW-1:0]    row_sel_o;
  logic               frame_done_o;
`ifdef SCAN_DOUBLE_BUFFER_EN
  logic               bank_o;
`endif

  modport master (
`ifdef SCAN_DOUBLE_BUFFER_EN
    output bank_o,
`endif
    input  frame_valid_i,
    input  rd_data_i,
    output frame_ready_o,
    output rd_en_o,
    output rd_addr_o,
    output serial_o,
    output shift_en_o,
    output latch_o,
    output blank_o,
    output row_sel_o,
    output frame_done_o
  );

  modport slave (
`ifdef SCAN_DOUBLE_BUFFER_EN
    input  bank_o,
`endif
    output frame_valid_i,
    output rd_data_i,
    input  frame_ready_o,
    input  rd_en_o,
    input  rd_addr_o,
    input  serial_o,
    input  shift_en_o,
    input  latch_o,
    input  blank_o,
    input  row_sel_o,
    input  frame_done_o
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// LED matrix frame scan sequencer: fetch, shift out, latch and display each row in turn.
// Optional SCAN_DOUBLE_BUFFER_EN: ping-pong RAM banks selected by bank_o.
module matrix_scan_ctrl #(
  parameter int unsigned RowW    = 32,
  parameter int unsigned ColW    = 16,
  parameter int unsigned AddrW   = 4,
  parameter int unsigned CntW    = 6,
  parameter int unsigned HoldCyc = 64
) (
  input logic                clk,
  input logic                rst,
  matrix_scan_ctrl_if.master bus
);

`ifdef SCAN_DOUBLE_BUFFER_EN
  localparam int unsigned RdAddrW = AddrW + 1;
`else
  localparam int unsigned RdAddrW = AddrW;
`endif
  localparam int unsigned HoldW = (HoldCyc > 1) ? $clog2(HoldCyc) : 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StWait, StShift, StLatch, StDisplay
  } state_e;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   row_q, row_d;
  logic [CntW-1:0]    bit_q, bit_d;
  logic [HoldW-1:0]   hold_q, hold_d;
  logic [RowW-1:0]    shreg_q, shreg_d;
  logic [ColW-1:0]    row_sel_q, row_sel_d;
`ifdef SCAN_DOUBLE_BUFFER_EN
  logic               bank_q, bank_d;
`endif

  logic               frame_ready;
  logic               rd_en;
  logic [RdAddrW-1:0] rd_addr;
  logic               serial;
  logic               shift_en;
  logic               latch;
  logic               blank;
  logic               frame_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      bit_q     <= '0;
      hold_q    <= '0;
      shreg_q   <= '0;
      row_sel_q <= '0;
`ifdef SCAN_DOUBLE_BUFFER_EN
      bank_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      bit_q     <= bit_d;
      hold_q    <= hold_d;
      shreg_q   <= shreg_d;
      row_sel_q <= row_sel_d;
`ifdef SCAN_DOUBLE_BUFFER_EN
      bank_q    <= bank_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    bit_d       = bit_q;
    hold_d      = hold_q;
    shreg_d     = shreg_q;
    row_sel_d   = row_sel_q;
`ifdef SCAN_DOUBLE_BUFFER_EN
    bank_d      = bank_q;
`endif
    frame_ready = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = '0;
    serial      = 1'b0;
    shift_en    = 1'b0;
    latch       = 1'b0;
    blank       = 1'b1;
    frame_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        frame_ready = 1'b1;
        if (bus.frame_valid_i) begin
          row_d   = '0;
          state_d = StFetch;
`ifdef SCAN_DOUBLE_BUFFER_EN
          // Writer owns the other bank; flip to the one it just completed.
          bank_d  = ~bank_q;
`endif
        end
      end
      StFetch: begin
        rd_en   = 1'b1;
`ifdef SCAN_DOUBLE_BUFFER_EN
        rd_addr = {bank_q, row_q};
`else
        rd_addr = row_q;
`endif
        state_d = StWait;
      end
      StWait: begin
        shreg_d = bus.rd_data_i;
        bit_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        shift_en = 1'b1;
        serial   = shreg_q[RowW-1];
        shreg_d  = shreg_q << 1;
        bit_d    = bit_q + 1'b1;
        if (bit_q == CntW'(RowW - 1)) begin
          state_d = StLatch;
        end
      end
      StLatch: begin
        latch     = 1'b1;
        row_sel_d = ColW'(1) << row_q;
        hold_d    = '0;
        state_d   = StDisplay;
      end
      StDisplay: begin
        blank  = 1'b0;
        hold_d = hold_q + 1'b1;
        if (hold_q == HoldW'(HoldCyc - 1)) begin
          if (row_q != AddrW'(ColW - 1)) begin
            row_d   = row_q + 1'b1;
            state_d = StFetch;
          end else begin
            // Pulse coincides with the final hold cycle so a held frame_valid_i
            // restarts after exactly one idle cycle.
            frame_done = 1'b1;
            row_sel_d  = '0;
            row_d      = '0;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.frame_ready_o = frame_ready;
  assign bus.rd_en_o       = rd_en;
  assign bus.rd_addr_o     = rd_addr;
  assign bus.serial_o      = serial;
  assign bus.shift_en_o    = shift_en;
  assign bus.latch_o       = latch;
  assign bus.blank_o       = blank;
  assign bus.row_sel_o     = row_sel_q;
  assign bus.frame_done_o  = frame_done;
`ifdef SCAN_DOUBLE_BUFFER_EN
  assign bus.bank_o        = bank_q;
`endif

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Self-checking bench for matrix_scan_ctrl: scoreboard of row words, addresses,
// row selects and frame-done times, filled at frame accept and drained by a monitor.
module tb_matrix_scan_ctrl;
  localparam int unsigned RowW     = 32;
  localparam int unsigned ColW     = 16;
  localparam int unsigned AddrW    = 4;
  localparam int unsigned CntW     = 6;
  localparam int unsigned HoldCyc  = 64;
  localparam int unsigned FrameCyc = ColW * (3 + RowW + HoldCyc);
`ifdef SCAN_DOUBLE_BUFFER_EN
  localparam int unsigned RdAddrW = AddrW + 1;
`else
  localparam int unsigned RdAddrW = AddrW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_scan_ctrl_if #(.RowW(RowW), .ColW(ColW), .AddrW(AddrW)) bus ();

  matrix_scan_ctrl #(
    .RowW(RowW), .ColW(ColW), .AddrW(AddrW), .CntW(CntW), .HoldCyc(HoldCyc)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [RowW-1:0] mem [32];
  int unsigned     cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= mem[int'(bus.rd_addr_o)];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard
  logic [RowW-1:0]    q_word[$];
  logic [RdAddrW-1:0] q_addr[$];
  int unsigned        q_row[$];
  int unsigned        q_done[$];

  logic               prev_ready, prev_latch, exp_bank;
  logic [RowW-1:0]    sh_word;
  logic [RdAddrW-1:0] m_addr;
  logic [ColW-1:0]    m_sel;
  int unsigned        sh_bits, blank_run;
  int unsigned        latch_cnt = 0;
  int unsigned        done_cnt = 0;
  int unsigned        last_done_cyc = 0;
  logic               multi_seen = 1'b0;
  logic               blank_bad = 1'b0;
  logic               idle_sel_bad = 1'b0;

  initial begin
    prev_ready = 1'b1;
    prev_latch = 1'b0;
    exp_bank   = 1'b1;
    sh_word    = '0;
    sh_bits    = 0;
    blank_run  = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q_word.delete(); q_addr.delete(); q_row.delete(); q_done.delete();
        prev_ready = 1'b1;
        prev_latch = 1'b0;
        exp_bank   = 1'b1;
        sh_bits    = 0;
        blank_run  = 0;
      end else begin
        // Accept seen as the first cycle with frame_ready_o low.
        if (prev_ready && !bus.frame_ready_o) begin
          exp_bank = ~exp_bank;
          for (int r = 0; r < int'(ColW); r++) begin
            m_addr = RdAddrW'(r);
`ifdef SCAN_DOUBLE_BUFFER_EN
            m_addr[AddrW] = exp_bank;
`endif
            q_addr.push_back(m_addr);
            q_word.push_back(mem[int'(m_addr)]);
            q_row.push_back(r);
          end
          q_done.push_back(cyc - 1 + FrameCyc);
        end
        if (bus.rd_en_o) begin
          if (q_addr.size() == 0) chk("rd_en_unexpected", bus.rd_en_o, 1'b0);
          else chk("rd_addr", bus.rd_addr_o, q_addr.pop_front());
        end
        if (bus.shift_en_o) begin
          sh_word = {sh_word[RowW-2:0], bus.serial_o};
          sh_bits++;
        end
        if (prev_latch) begin
          if (q_row.size() == 0) chk("row_sel_unexpected", bus.row_sel_o, '0);
          else begin
            m_sel = ColW'(1) << q_row.pop_front();
            chk("row_sel", bus.row_sel_o, m_sel);
          end
        end
        if (bus.latch_o) begin
          latch_cnt++;
          chk("shift_len", sh_bits, RowW);
          if (q_word.size() == 0) chk("latch_unexpected", bus.latch_o, 1'b0);
          else chk("row_word", sh_word, q_word.pop_front());
          sh_bits = 0;
        end
        if (!bus.blank_o) begin
          blank_run++;
          if (bus.shift_en_o || bus.latch_o || bus.rd_en_o || bus.frame_ready_o) blank_bad = 1'b1;
        end else if (blank_run != 0) begin
          chk("blank_len", blank_run, HoldCyc);
          blank_run = 0;
        end
        if ($countones(bus.row_sel_o) > 1) multi_seen = 1'b1;
        if (bus.frame_ready_o && bus.row_sel_o != '0) idle_sel_bad = 1'b1;
        if (bus.frame_done_o) begin
          done_cnt++;
          last_done_cyc = cyc;
          if (q_done.size() == 0) chk("done_unexpected", bus.frame_done_o, 1'b0);
          else chk("done_time", cyc, q_done.pop_front());
        end
      end
      prev_ready = bus.frame_ready_o;
      prev_latch = bus.latch_o;
    end
  end

  task automatic wait_ready_low(input string tag);
    int n = 0;
    while (bus.frame_ready_o && n < 10) begin @(negedge clk); n++; end
    chk(tag, bus.frame_ready_o, 1'b0);
  endtask

  task automatic wait_done(input int unsigned prev, input string tag);
    int unsigned n = 0;
    while (done_cnt == prev && n < FrameCyc + 50) begin @(negedge clk); n++; end
    chk(tag, done_cnt != prev, 1'b1);
  endtask

  int unsigned lc, dc, d1;

  initial begin
    bus.frame_valid_i = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h8000_0001;

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", bus.frame_ready_o, 1'b1);
    chk("rst_blank", bus.blank_o, 1'b1);
    chk("rst_row_sel", bus.row_sel_o, '0);
    chk("rst_rd_en", bus.rd_en_o, 1'b0);
    chk("rst_rd_addr", bus.rd_addr_o, '0);
    chk("rst_shift_en", bus.shift_en_o, 1'b0);
    chk("rst_serial", bus.serial_o, 1'b0);
    chk("rst_latch", bus.latch_o, 1'b0);
    chk("rst_done", bus.frame_done_o, 1'b0);
`ifdef SCAN_DOUBLE_BUFFER_EN
    chk("rst_bank", bus.bank_o, 1'b1);
`endif
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;

    // Single frame of 32'h8000_0001 rows, with frame_valid_i wiggled mid-frame
    @(negedge clk);
    lc = latch_cnt; dc = done_cnt;
    bus.frame_valid_i = 1'b1;
    wait_ready_low("accept_a");
    bus.frame_valid_i = 1'b0;
    repeat (20) @(negedge clk);
    bus.frame_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    bus.frame_valid_i = 1'b0;
    repeat (150) @(negedge clk);
    bus.frame_valid_i = 1'b1;
    @(negedge clk);
    bus.frame_valid_i = 1'b0;
    wait_done(dc, "done_a_timeout");
    chk("latches_a", latch_cnt - lc, ColW);
    repeat (5) @(negedge clk);
    chk("no_restart_ready", bus.frame_ready_o, 1'b1);
    chk("no_restart_latch", latch_cnt - lc, ColW);
    chk("idle_row_sel", bus.row_sel_o, '0);

    // Reset in the middle of row 1's shift abandons the frame
    bus.frame_valid_i = 1'b1;
    lc = latch_cnt;
    wait_ready_low("accept_rst");
    bus.frame_valid_i = 1'b0;
    begin
      int n = 0;
      while (!(latch_cnt > lc && bus.shift_en_o) && n < 300) begin @(negedge clk); n++; end
      chk("reach_row1_shift", bus.shift_en_o, 1'b1);
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("midrst_blank", bus.blank_o, 1'b1);
    chk("midrst_ready", bus.frame_ready_o, 1'b1);
    chk("midrst_row_sel", bus.row_sel_o, '0);
    chk("midrst_latch", bus.latch_o, 1'b0);
    chk("midrst_shift_en", bus.shift_en_o, 1'b0);
`ifdef SCAN_DOUBLE_BUFFER_EN
    chk("midrst_bank", bus.bank_o, 1'b1);
`endif
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    lc = latch_cnt;
    repeat (300) @(negedge clk);
    chk("post_rst_latch", latch_cnt - lc, 0);
    chk("post_rst_ready", bus.frame_ready_o, 1'b1);

    // Back-to-back frames with random row data
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    lc = latch_cnt; dc = done_cnt;
    bus.frame_valid_i = 1'b1;
    wait_done(dc, "done_b_timeout");
    d1 = last_done_cyc;
    begin
      int n = 0;
      while (!bus.rd_en_o && n < 10) begin @(negedge clk); n++; end
      chk("b2b_gap", cyc - d1, 2);
    end
    bus.frame_valid_i = 1'b0;
    wait_done(dc + 1, "done_c_timeout");
    chk("latches_bc", latch_cnt - lc, 2 * ColW);
    repeat (5) @(negedge clk);

    chk("row_sel_onehot", multi_seen, 1'b0);
    chk("blank_only_display", blank_bad, 1'b0);
    chk("idle_row_sel_zero", idle_sel_bad, 1'b0);
    chk("sb_words_drained", q_word.size(), 0);
    chk("sb_done_drained", q_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
